axis_testpattern_sequencer: RTL and testbench
=============================================

# axis_testpattern_sequencer

Burst scheduler placed between an `axis_testpattern_generator` instance and the downstream AXI-Stream consumer. It drives the generator's `enable`, forwards beats only during scheduled bursts, and runs a programmable number of fixed-length bursts separated by idle gaps. The stream data is passed through combinationally and gated by registered state. Completion and activity are reported via `busy` and `done`.

## Interface
- `DATA_WIDTH`, 8, tdata width on both stream ports
- `LEN_WIDTH`, 16, width of `burst_len`, `gap_len` and the internal counters
- `REP_WIDTH`, 8, width of `repeat_count`
- `m_axis_aclk`  in  1  single clock for all logic
- `m_axis_areset`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin a sequence; sampled in IDLE only
- `stop`  in  1  request graceful stop
- `burst_len`  in  LEN_WIDTH  beats per burst, sampled on start; 0 treated as 1
- `gap_len`  in  LEN_WIDTH  idle cycles between bursts, sampled on start
- `repeat_count`  in  REP_WIDTH  number of bursts, sampled on start; 0 = run until stop
- `gen_enable`  out  1  enable to the generator
- `s_axis_tdata`  in  DATA_WIDTH  from the generator
- `s_axis_tvalid`  in  1  from the generator
- `s_axis_tready`  out  1  to the generator
- `m_axis_tdata`  out  DATA_WIDTH  equals `s_axis_tdata`
- `m_axis_tvalid`  out  1  downstream valid
- `m_axis_tready`  in  1  downstream ready
- `m_axis_tlast`  out  1  last beat of a burst (only with macro, see Configuration)
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse at sequence end

## Operation
- States: IDLE, BURST, GAP.
- IDLE:
  - `start`=1 and `stop`=0 latches the configuration, clears the beat and burst counters, and moves to BURST.
  - `stop` in IDLE is ignored.
  - `start` and `stop` in the same cycle: stop wins, the sequencer stays in IDLE.
- BURST:
  - `gen_enable`=1.
  - `m_axis_tvalid` = `s_axis_tvalid`; `s_axis_tready` = `m_axis_tready`.
  - A beat is counted when `m_axis_tvalid & m_axis_tready`.
  - On the handshake with beat count = burst_len-1, the burst ends:
    - Sequence over (stop latched, or repeat_count≠0 and burst count = repeat_count-1): go to IDLE and pulse `done`.
    - Otherwise, gap_len=0: go straight to BURST with counters reset (back-to-back).
    - Otherwise: go to GAP.
- GAP:
  - `gen_enable`=0, `s_axis_tready`=0, `m_axis_tvalid`=0.
  - Counts gap_len cycles, then returns to BURST.
  - `stop` in GAP goes to IDLE on the next edge with a `done` pulse.
- Stop during BURST is latched and never truncates a burst. Because `m_axis_tvalid` only drops at a beat boundary, the AXIS rule is kept (no valid withdrawal without a handshake).
- Burst counter wraps at 2^REP_WIDTH in the infinite mode (repeat_count=0). Beat and gap counters never exceed their latched limits.
- Configuration inputs changing while busy have no effect until the next start.

## Timing
- Reset values: state IDLE, `gen_enable`=0, `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `busy`=0, `done`=0, all counters 0.
- Reset mid-burst forces all of the above immediately (asynchronously), without waiting for a clock edge.
- `start` sampled at edge t: `busy`, `gen_enable` and tvalid gating are active from t+1.
- Data path latency: 0 cycles; tdata/tvalid/tready pass combinationally while in BURST.
- GAP of gap_len=N: exactly N cycles with `m_axis_tvalid`=0 between the last beat of one burst and the first possible beat of the next.
- `done` is high for exactly the one cycle after the final handshake (or after the GAP-stop edge). `busy` falls in that same cycle.

## Configuration
- Macro `TESTPATTERN_SEQ_TLAST_EN`.
- Defined: the `m_axis_tlast` port exists. It is 1 whenever `m_axis_tvalid`=1 and the beat count = burst_len-1, else 0.
- Undefined: the port and its logic are omitted; all other behaviour is identical.

## Test plan
- Basic run: burst_len=4, gap_len=3, repeat_count=2, tready=1, start pulse -> two bursts of 4 beats with exactly 3 valid-low cycles between them; `done` pulses 1 cycle after beat 8; tlast on beats 4 and 8.
- Back-to-back: gap_len=0, burst_len=3, repeat_count=3 -> 9 consecutive beats, tvalid never drops; tlast on beats 3, 6 and 9.
- Backpressure: tready toggled 0/1 every 20 ns during a burst -> 4 beats are still counted, tvalid is held until accepted, and tdata matches the generator sequence with no loss or duplication.
- Stop handling:
  - stop mid-burst (repeat_count=0) -> the burst completes all burst_len beats, then IDLE and `done`.
  - stop in GAP -> IDLE next cycle with `done`.
  - start and stop in the same cycle in IDLE -> stays IDLE.
- Reset mid-burst: assert `m_axis_areset` between edges after 2 beats -> `gen_enable`, `m_axis_tvalid` and `s_axis_tready` go to 0 immediately; after release the sequencer stays IDLE until the next start.
- Edge config: burst_len=0 -> bursts of 1 beat each.

Source files
------------

// File: rtl/axis_testpattern_sequencer_if.sv
// AXI-Stream beat bus (tdata/tvalid/tready) shared by the sequencer's input and output ports.
// master drives data/valid and samples ready; slave is the mirror image.
interface axis_testpattern_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_testpattern_sequencer.sv
// Burst scheduler between a test-pattern generator and an AXIS sink: N bursts of fixed length separated by idle gaps.
// Latency 0 (combinational pass-through gated by registered state); optional tlast via TESTPATTERN_SEQ_TLAST_EN.
module axis_testpattern_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int REP_WIDTH  = 8
) (
    input  logic                  m_axis_aclk,
    input  logic                  m_axis_areset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [LEN_WIDTH-1:0]  gap_len,
    input  logic [REP_WIDTH-1:0]  repeat_count,
    output logic                  gen_enable,
    axis_testpattern_sequencer_if.slave  s_axis,
    axis_testpattern_sequencer_if.master m_axis,
`ifdef TESTPATTERN_SEQ_TLAST_EN
    output logic                  m_axis_tlast,
`endif
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  len_q, gap_lim_q, beat_q, gap_q;
    logic [REP_WIDTH-1:0]  rep_lim_q, rep_q;
    logic                  stop_q, done_q;

    logic                  in_burst, hs, last_beat, rep_last, seq_over;
    logic [DATA_WIDTH-1:0] pass_dat;

    assign in_burst      = (state_q == BURST);
    assign pass_dat      = s_axis.tdata;
    assign m_axis.tdata  = pass_dat;
    assign m_axis.tvalid = in_burst & s_axis.tvalid;
    assign s_axis.tready = in_burst & m_axis.tready;
    assign hs            = m_axis.tvalid & m_axis.tready;

    assign last_beat = (beat_q == len_q - LEN_WIDTH'(1));
    assign rep_last  = (rep_lim_q != '0) && (rep_q == rep_lim_q - REP_WIDTH'(1));
    // A stop arriving on the final beat's cycle ends the sequence just like a latched one.
    assign seq_over  = stop_q | stop | rep_last;

    assign gen_enable = in_burst;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
`ifdef TESTPATTERN_SEQ_TLAST_EN
    assign m_axis_tlast = m_axis.tvalid & last_beat;
`endif

    always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
        if (m_axis_areset) begin
            state_q   <= IDLE;
            len_q     <= '0;
            gap_lim_q <= '0;
            rep_lim_q <= '0;
            beat_q    <= '0;
            gap_q     <= '0;
            rep_q     <= '0;
            stop_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        len_q     <= (burst_len == '0) ? LEN_WIDTH'(1) : burst_len;
                        gap_lim_q <= gap_len;
                        rep_lim_q <= repeat_count;
                        beat_q    <= '0;
                        gap_q     <= '0;
                        rep_q     <= '0;
                        stop_q    <= 1'b0;
                        state_q   <= BURST;
                    end
                end
                BURST: begin
                    if (stop) stop_q <= 1'b1;
                    if (hs) begin
                        if (last_beat) begin
                            beat_q <= '0;
                            if (seq_over) begin
                                stop_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= IDLE;
                            end else begin
                                rep_q <= rep_q + REP_WIDTH'(1);
                                if (gap_lim_q != '0) begin
                                    gap_q   <= '0;
                                    state_q <= GAP;
                                end
                            end
                        end else begin
                            beat_q <= beat_q + LEN_WIDTH'(1);
                        end
                    end
                end
                GAP: begin
                    if (stop) begin
                        gap_q   <= '0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (gap_q == gap_lim_q - LEN_WIDTH'(1)) begin
                        gap_q   <= '0;
                        state_q <= BURST;
                    end else begin
                        gap_q <= gap_q + LEN_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_testpattern_sequencer.sv
// Scoreboard bench: tests push expected beats, a negedge monitor pops and compares every downstream handshake.
module tb_axis_testpattern_sequencer;
    logic        clk, rst, start, stop, m_tready, gen_clr;
    logic [15:0] burst_len, gap_len;
    logic [7:0]  repeat_count, gen_cnt;
    logic        gen_enable, busy, done;
`ifdef TESTPATTERN_SEQ_TLAST_EN
    logic        m_tlast;
`endif

    axis_testpattern_sequencer_if #(.DATA_WIDTH(8)) s_if ();
    axis_testpattern_sequencer_if #(.DATA_WIDTH(8)) m_if ();

    axis_testpattern_sequencer dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (rst),
        .start         (start),
        .stop          (stop),
        .burst_len     (burst_len),
        .gap_len       (gap_len),
        .repeat_count  (repeat_count),
        .gen_enable    (gen_enable),
        .s_axis        (s_if),
        .m_axis        (m_if),
`ifdef TESTPATTERN_SEQ_TLAST_EN
        .m_axis_tlast  (m_tlast),
`endif
        .busy          (busy),
        .done          (done)
    );

    // Generator model: valid whenever enabled, data is a beat counter advancing on accept.
    assign s_if.tvalid = gen_enable;
    assign s_if.tdata  = gen_cnt;
    assign m_if.tready = m_tready;
    always @(posedge clk) begin
        if (gen_clr) gen_cnt <= 8'd0;
        else if (s_if.tvalid && s_if.tready) gen_cnt <= gen_cnt + 8'd1;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct { logic [7:0] d; logic l; } beat_t;
    beat_t exp_q[$];
    int n_checks = 0, n_pass = 0;
    int last_hs_cyc = 0, low_run = 0, max_low = 0;
    logic       pend = 1'b0;
    logic [7:0] pend_dat = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, req);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (busy && !m_if.tvalid) low_run++;
            if (pend) begin
                chk("hold_valid", {31'd0, m_if.tvalid}, 32'd1);
                chk("hold_data", {24'd0, m_if.tdata}, {24'd0, pend_dat});
            end
            if (m_if.tvalid && m_tready) begin
                if (low_run > max_low) max_low = low_run;
                low_run = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got data %0d, required no beat", m_if.tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", {24'd0, m_if.tdata}, {24'd0, e.d});
`ifdef TESTPATTERN_SEQ_TLAST_EN
                    chk("beat_tlast", {31'd0, m_tlast}, {31'd0, e.l});
`endif
                end
                last_hs_cyc = cyc;
                pend = 1'b0;
            end else begin
                pend     = m_if.tvalid;
                pend_dat = m_if.tdata;
            end
        end
    end

    task automatic push_beats(input int n, input int eff);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.d = 8'(i);
            e.l = ((i % eff) == eff - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_seq(input logic [15:0] bl, input logic [15:0] gl, input logic [7:0] rc);
        @(posedge clk); #1 gen_clr = 1'b1;
        @(posedge clk); #1 gen_clr = 1'b0;
        burst_len = bl; gap_len = gl; repeat_count = rc; start = 1'b1;
        low_run = 0; max_low = 0;
        @(posedge clk); #1 start = 1'b0;
        // Configuration changes while busy must not matter.
        burst_len = 16'd9; gap_len = 16'd7; repeat_count = 8'd5;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("gen_en_after_start", {31'd0, gen_enable}, 32'd1);
    endtask

    task automatic wait_done(input int budget, output int dc);
        logic found = 1'b0;
        dc = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                dc = cyc;
            end
        end
        chk("done_seen", {31'd0, found}, 32'd1);
        if (found) begin
            chk("busy_falls_with_done", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        int dc;
        rst = 1'b1; start = 1'b0; stop = 1'b0; m_tready = 1'b1; gen_clr = 1'b1;
        burst_len = 16'd0; gap_len = 16'd0; repeat_count = 8'd0;
        #12;
        chk("rst_gen_en", {31'd0, gen_enable}, 32'd0);
        chk("rst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst_s_tready", {31'd0, s_if.tready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic: 2 bursts of 4, gap 3.
        push_beats(8, 4);
        start_seq(16'd4, 16'd3, 8'd2);
        wait_done(60, dc);
        chk("basic_done_latency", 32'(dc - last_hs_cyc), 32'd1);
        chk("basic_gap_len", 32'(max_low), 32'd3);
        chk("basic_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back: 3 bursts of 3, no gap.
        push_beats(9, 3);
        start_seq(16'd3, 16'd0, 8'd3);
        wait_done(60, dc);
        chk("b2b_done_latency", 32'(dc - last_hs_cyc), 32'd1);
        chk("b2b_no_valid_drop", 32'(max_low), 32'd0);
        chk("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: downstream ready toggles every 20 ns.
        push_beats(4, 4);
        start_seq(16'd4, 16'd0, 8'd1);
        fork
            begin
                repeat (10) begin
                    m_tready = ~m_tready;
                    #20;
                end
            end
        join_none
        wait_done(80, dc);
        wait fork;
        m_tready = 1'b1;
        chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stop mid-burst in infinite mode: the burst still completes.
        push_beats(4, 4);
        start_seq(16'd4, 16'd2, 8'd0);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done(40, dc);
        chk("stop_burst_done_latency", 32'(dc - last_hs_cyc), 32'd1);
        chk("stop_burst_sb_empty", 32'(exp_q.size()), 32'd0);

        // Stop during GAP: done on the cycle after the stop edge.
        push_beats(2, 2);
        start_seq(16'd2, 16'd5, 8'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        wait_done(5, dc);
        chk("stop_gap_done_latency", 32'(dc - last_hs_cyc), 32'd3);
        chk("stop_gap_sb_empty", 32'(exp_q.size()), 32'd0);

        // start and stop together in IDLE: nothing happens.
        @(posedge clk); #1 start = 1'b1; stop = 1'b1; burst_len = 16'd2; repeat_count = 8'd1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        chk("startstop_busy", {31'd0, busy}, 32'd0);
        chk("startstop_gen_en", {31'd0, gen_enable}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("startstop_still_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset after 2 beats.
        push_beats(2, 6);
        start_seq(16'd6, 16'd0, 8'd1);
        @(posedge clk); #1;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("arst_gen_en", {31'd0, gen_enable}, 32'd0);
        chk("arst_tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("arst_s_tready", {31'd0, s_if.tready}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_idle", {31'd0, busy}, 32'd0);
        chk("post_rst_gen_en", {31'd0, gen_enable}, 32'd0);
        chk("rst_sb_empty", 32'(exp_q.size()), 32'd0);

        // burst_len 0 behaves as 1.
        push_beats(3, 1);
        start_seq(16'd0, 16'd1, 8'd3);
        wait_done(40, dc);
        chk("len0_gap_len", 32'(max_low), 32'd1);
        chk("len0_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
